trap_dump_unit: RTL and testbench
=================================

Name: trap_dump_unit

Overview:
- Hardware counterpart to the bench-side end-of-program handling of the single-cycle core.
- Watches the fetched instruction for the halting trap word (0x44000300) and asserts halt to freeze the core.
- Then walks a window of byte-wide data memory and assembles big-endian 32-bit words.
- Streams {address, word} pairs out on a valid/ready interface, for a host, UART bridge or checker to consume.

Parameters:
- TRAP_WORD, 32'h44000300, instruction encoding that triggers halt and dump.
- DUMP_BASE, 32'h00002000, byte address of first dumped word; must be 4-byte aligned.
- DUMP_WORDS, 64, number of 32-bit words to emit; 0 is legal.
- CNT_W, 16, width of the word counter; must satisfy DUMP_WORDS < 2^CNT_W.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  instruction qualifier; the trap is only recognised when high.
- instruction  in  32  current fetched instruction from the core.
- halt  out  1  freezes the core's PC/register writes while high.
- mem_rd  out  1  data-memory byte read strobe.
- mem_addr  out  32  byte address for the read.
- mem_byte  in  8  read data, valid the cycle after mem_rd.
- dump_valid  out  1  dump_addr/dump_data hold a word.
- dump_ready  in  1  consumer accepts the word.
- dump_addr  out  32  byte address of the emitted word.
- dump_data  out  32  word value, big-endian: mem[a] in bits 31:24 through mem[a+3] in bits 7:0.
- words_sent  out  CNT_W  count of accepted words.
- done  out  1  dump complete.

Behaviour:
- Reset values: halt, mem_rd, dump_valid and done are 0; mem_addr, dump_addr, dump_data and words_sent are 0; state is IDLE.
- Reset takes priority over all other inputs, including mid-dump. The FSM returns to IDLE, halt drops, and the partial word is discarded.

States:
- IDLE
  - If enable and instruction == TRAP_WORD at an edge: halt = 1 from the next cycle.
  - Clear the word index w.
  - Next state is FETCH, or DONE if DUMP_WORDS == 0.
- FETCH: 4 cycles, byte counter b = 0..3.
  - mem_rd = 1 and mem_addr = DUMP_BASE + 4*w + b.
  - The byte returned the cycle after each read is shifted into the assembly register, MSB first.
- CAPT: 1 cycle.
  - mem_rd = 0; the last byte (b = 3) is captured.
  - Next state is VALID.
- VALID
  - dump_valid = 1; dump_addr = DUMP_BASE + 4*w; dump_data is the assembled word.
  - All three outputs stay stable until the handshake completes.
  - Transfer occurs on an edge with dump_valid && dump_ready. On transfer: words_sent++ and w++.
  - Then go to FETCH if w + 1 < DUMP_WORDS, otherwise to DONE.
  - dump_valid deasserts the cycle after transfer.
- DONE
  - done = 1 and halt stays 1 until reset.
  - Trap words are ignored.

Timing and side rules:
- First FETCH cycle is T. dump_valid is high at T+5.
- With dump_ready tied high, the sustained rate is one word per 6 cycles. Total dump time is 6*DUMP_WORDS cycles after the trap edge, plus 1.
- mem_addr is 0 whenever mem_rd = 0.
- Address arithmetic is modulo 2^32: a window crossing 0xFFFFFFFF wraps to 0x00000000.
- A trap word with enable = 0 is ignored.
- A trap re-presented while halted (the core is frozen, so it is constant) is ignored outside IDLE.
- dump_ready high outside VALID has no effect.
- halt is registered and never glitches combinationally from instruction.

Test Plan:
- Reset, drive instruction = 0x20010005 with enable = 1 for 20 cycles -> halt = 0, dump_valid = 0, done = 0, mem_rd = 0 throughout.
- Preload mem[0x2000..0x2007] = 01 02 03 04 AA BB CC DD; DUMP_WORDS = 2; trap with dump_ready = 1 -> halt = 1 next cycle. Then emit (0x2000, 0x01020304) followed by (0x2004, 0xAABBCCDD) 6 cycles apart; done = 1 and words_sent = 2.
- Same setup, dump_ready held 0 for 10 cycles on word 0 -> dump_valid, dump_addr and dump_data are unchanged for all 10 cycles; exactly one transfer when ready rises; mem_rd stays 0 while stalled.
- DUMP_WORDS = 0, trap -> halt = 1 and done = 1 on the cycle after the trap edge; dump_valid never asserts.
- DUMP_BASE = 0xFFFFFFFC, DUMP_WORDS = 2 -> the second word has dump_addr = 0x00000000, and its reads hit mem_addr 0x0..0x3.
- Assert reset during FETCH of word 1 -> next cycle all outputs are 0 and the FSM is in IDLE. A new trap restarts the dump at DUMP_BASE with words_sent starting from 0.

Source files
------------

// File: rtl/trap_dump_unit.sv
// trap_dump_unit
//
// Watches the fetched instruction for the halting trap word. On a qualified
// trap it freezes the core (halt). It then reads a window of byte-wide data
// memory, assembles big-endian 32-bit words and streams {address, word}
// pairs out on a valid/ready interface.
//
// Ports:
//   clock        system clock, all state changes on the rising edge
//   reset        synchronous active-high reset, overrides everything
//   enable       instruction qualifier; a trap only counts while high
//   instruction  current fetched instruction
//   halt         freezes the core while high (registered)
//   mem_rd       data-memory byte read strobe
//   mem_addr     byte address for the read (0 when mem_rd is low)
//   mem_byte     read data, valid the cycle after mem_rd
//   dump_valid   dump_addr/dump_data hold a word
//   dump_ready   consumer accepts the word
//   dump_addr    byte address of the emitted word
//   dump_data    emitted word, mem[a] in bits 31:24 .. mem[a+3] in bits 7:0
//   words_sent   number of accepted words
//   done         dump complete; stays high with halt until reset
module trap_dump_unit #(
  parameter logic [31:0] TRAP_WORD  = 32'h44000300,
  parameter logic [31:0] DUMP_BASE  = 32'h00002000,
  parameter int unsigned DUMP_WORDS = 64,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [31:0]      instruction,
  output logic             halt,
  output logic             mem_rd,
  output logic [31:0]      mem_addr,
  input  logic [7:0]       mem_byte,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [31:0]      dump_addr,
  output logic [31:0]      dump_data,
  output logic [CNT_W-1:0] words_sent,
  output logic             done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    CAPT  = 3'd2,
    VALID = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [31:0]      DUMP_WORDS_W = 32'(DUMP_WORDS);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  state_t             state_r;
  logic [CNT_W-1:0]   w_r;           // index of the word being dumped
  logic [1:0]         b_r;           // byte index within the word
  logic [23:0]        asm_r;         // first three bytes, MSB first
  logic               halt_r;
  logic               mem_rd_r;
  logic [31:0]        mem_addr_r;
  logic               dump_valid_r;
  logic [31:0]        dump_addr_r;
  logic [31:0]        dump_data_r;
  logic [CNT_W-1:0]   words_sent_r;
  logic               done_r;

  logic [CNT_W-1:0]   next_w_s;
  logic               more_s;
  logic               trap_s;

  // Byte address of word idx; wraps modulo 2^32.
  function automatic logic [31:0] word_addr(input logic [CNT_W-1:0] idx);
    logic [31:0] wide;
    wide = 32'(idx);
    return DUMP_BASE + {wide[29:0], 2'b00};
  endfunction

  assign next_w_s = w_r + CNT_ONE;
  assign more_s   = (32'(next_w_s) < DUMP_WORDS_W);
  assign trap_s   = enable && (instruction == TRAP_WORD);

  assign halt       = halt_r;
  assign mem_rd     = mem_rd_r;
  assign mem_addr   = mem_addr_r;
  assign dump_valid = dump_valid_r;
  assign dump_addr  = dump_addr_r;
  assign dump_data  = dump_data_r;
  assign words_sent = words_sent_r;
  assign done       = done_r;

  // Dump sequencer: state plus all registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= IDLE;
      w_r          <= '0;
      b_r          <= 2'd0;
      asm_r        <= 24'h000000;
      halt_r       <= 1'b0;
      mem_rd_r     <= 1'b0;
      mem_addr_r   <= 32'h00000000;
      dump_valid_r <= 1'b0;
      dump_addr_r  <= 32'h00000000;
      dump_data_r  <= 32'h00000000;
      words_sent_r <= '0;
      done_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (trap_s) begin
            halt_r <= 1'b1;
            w_r    <= '0;
            b_r    <= 2'd0;
            if (DUMP_WORDS_W == 32'd0) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end else begin
              // Issue the first read on entry so it is live in the first FETCH cycle.
              state_r    <= FETCH;
              mem_rd_r   <= 1'b1;
              mem_addr_r <= word_addr('0);
            end
          end else begin
            state_r <= IDLE;
          end
        end

        FETCH: begin
          // Byte b-1 returns during cycle b; byte 0 has not arrived yet at b = 0.
          if (b_r != 2'd0) begin
            asm_r <= {asm_r[15:0], mem_byte};
          end else begin
            asm_r <= asm_r;
          end
          if (b_r == 2'd3) begin
            state_r    <= CAPT;
            mem_rd_r   <= 1'b0;
            mem_addr_r <= 32'h00000000;
          end else begin
            b_r        <= b_r + 2'd1;
            mem_addr_r <= mem_addr_r + 32'd1;
          end
        end

        CAPT: begin
          // Last byte comes straight off the memory bus.
          state_r      <= VALID;
          dump_valid_r <= 1'b1;
          dump_addr_r  <= word_addr(w_r);
          dump_data_r  <= {asm_r, mem_byte};
        end

        VALID: begin
          if (dump_ready) begin
            dump_valid_r <= 1'b0;
            words_sent_r <= words_sent_r + CNT_ONE;
            w_r          <= next_w_s;
            if (more_s) begin
              state_r    <= FETCH;
              b_r        <= 2'd0;
              mem_rd_r   <= 1'b1;
              mem_addr_r <= word_addr(next_w_s);
            end else begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end
          end else begin
            state_r <= VALID;
          end
        end

        DONE: begin
          // Terminal: only reset leaves this state.
          state_r <= DONE;
          halt_r  <= 1'b1;
          done_r  <= 1'b1;
        end

        default: begin
          state_r      <= IDLE;
          halt_r       <= 1'b0;
          mem_rd_r     <= 1'b0;
          mem_addr_r   <= 32'h00000000;
          dump_valid_r <= 1'b0;
          done_r       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trap_dump_unit.sv
module tb_trap_dump_unit;

  localparam logic [31:0] TRAP = 32'h44000300;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Instance A: base 0x2000, two words
  logic        en_a = 1'b0, rdy_a = 1'b0, halt_a, rd_a, dv_a, done_a;
  logic [31:0] ins_a = 32'h0, addr_a, daddr_a, ddata_a;
  logic [7:0]  mb_a = 8'h00;
  logic [15:0] ws_a;
  // Instance Z: zero words
  logic        en_z = 1'b0, rdy_z = 1'b0, halt_z, rd_z, dv_z, done_z;
  logic [31:0] ins_z = 32'h0, addr_z, daddr_z, ddata_z;
  logic [7:0]  mb_z = 8'h00;
  logic [15:0] ws_z;
  // Instance W: base 0xFFFFFFFC, two words (wraps)
  logic        en_w = 1'b0, rdy_w = 1'b0, halt_w, rd_w, dv_w, done_w;
  logic [31:0] ins_w = 32'h0, addr_w, daddr_w, ddata_w;
  logic [7:0]  mb_w = 8'h00;
  logic [15:0] ws_w;

  int addr_viol = 0;
  int zero_valid_seen = 0;

  trap_dump_unit #(.DUMP_BASE(32'h00002000), .DUMP_WORDS(2)) u_a (
    .clock(clock), .reset(reset), .enable(en_a), .instruction(ins_a),
    .halt(halt_a), .mem_rd(rd_a), .mem_addr(addr_a), .mem_byte(mb_a),
    .dump_valid(dv_a), .dump_ready(rdy_a), .dump_addr(daddr_a),
    .dump_data(ddata_a), .words_sent(ws_a), .done(done_a));

  trap_dump_unit #(.DUMP_BASE(32'h00002000), .DUMP_WORDS(0)) u_z (
    .clock(clock), .reset(reset), .enable(en_z), .instruction(ins_z),
    .halt(halt_z), .mem_rd(rd_z), .mem_addr(addr_z), .mem_byte(mb_z),
    .dump_valid(dv_z), .dump_ready(rdy_z), .dump_addr(daddr_z),
    .dump_data(ddata_z), .words_sent(ws_z), .done(done_z));

  trap_dump_unit #(.DUMP_BASE(32'hFFFFFFFC), .DUMP_WORDS(2)) u_w (
    .clock(clock), .reset(reset), .enable(en_w), .instruction(ins_w),
    .halt(halt_w), .mem_rd(rd_w), .mem_addr(addr_w), .mem_byte(mb_w),
    .dump_valid(dv_w), .dump_ready(rdy_w), .dump_addr(daddr_w),
    .dump_data(ddata_w), .words_sent(ws_w), .done(done_w));

  function automatic logic [7:0] mem_model(input logic [31:0] a);
    case (a)
      32'h00002000: return 8'h01;
      32'h00002001: return 8'h02;
      32'h00002002: return 8'h03;
      32'h00002003: return 8'h04;
      32'h00002004: return 8'hAA;
      32'h00002005: return 8'hBB;
      32'h00002006: return 8'hCC;
      32'h00002007: return 8'hDD;
      32'hFFFFFFFC: return 8'h11;
      32'hFFFFFFFD: return 8'h22;
      32'hFFFFFFFE: return 8'h33;
      32'hFFFFFFFF: return 8'h44;
      32'h00000000: return 8'h55;
      32'h00000001: return 8'h66;
      32'h00000002: return 8'h77;
      32'h00000003: return 8'h88;
      default:      return 8'h00;
    endcase
  endfunction

  // Byte memories: data the cycle after the read strobe.
  always @(posedge clock) begin
    mb_a <= rd_a ? mem_model(addr_a) : 8'h00;
    mb_z <= rd_z ? mem_model(addr_z) : 8'h00;
    mb_w <= rd_w ? mem_model(addr_w) : 8'h00;
  end

  // Watch for a nonzero address without a read, and any valid from Z.
  always @(negedge clock) begin
    if (!rd_a && addr_a != 32'h0) addr_viol++;
    if (!rd_w && addr_w != 32'h0) addr_viol++;
    if (!rd_z && addr_z != 32'h0) addr_viol++;
    if (dv_z) zero_valid_seen++;
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    en_a = 1'b0; ins_a = 32'h0; en_z = 1'b0; ins_z = 32'h0; en_w = 1'b0; ins_w = 32'h0;
    reset = 1'b1;
    tick(2);
    checks++;
    if ({halt_a, rd_a, dv_a, done_a, halt_z, rd_z, dv_z, done_z, halt_w, rd_w, dv_w, done_w} !== 12'h000) begin
      errors++; $display("FAIL reset_flags: got %b required all zero",
        {halt_a, rd_a, dv_a, done_a, halt_z, rd_z, dv_z, done_z, halt_w, rd_w, dv_w, done_w});
    end
    checks++;
    if ({addr_a, daddr_a, ddata_a, ws_a} !== 112'h0) begin
      errors++; $display("FAIL reset_values: addr=%h daddr=%h ddata=%h ws=%0d required 0", addr_a, daddr_a, ddata_a, ws_a);
    end
    reset = 1'b0;
    tick(1);
  endtask

  task automatic test_no_trap();
    en_a = 1'b1; ins_a = 32'h20010005;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      checks++;
      if ({halt_a, dv_a, done_a, rd_a} !== 4'b0000) begin
        errors++; $display("FAIL no_trap cycle %0d: halt/valid/done/rd=%b required 0000", i, {halt_a, dv_a, done_a, rd_a});
      end
    end
  endtask

  task automatic test_enable_low();
    en_a = 1'b0; ins_a = TRAP;
    tick(4);
    checks++;
    if ({halt_a, rd_a, done_a} !== 3'b000) begin
      errors++; $display("FAIL enable_low: halt/rd/done=%b required 000", {halt_a, rd_a, done_a});
    end
  endtask

  task automatic test_dump_two();
    rdy_a = 1'b1; en_a = 1'b1; ins_a = TRAP;
    tick(1);
    checks++;
    if (halt_a !== 1'b1 || rd_a !== 1'b1 || addr_a !== 32'h00002000) begin
      errors++; $display("FAIL dump_start: halt=%b rd=%b addr=%h required 1 1 00002000", halt_a, rd_a, addr_a);
    end
    tick(3);
    checks++;
    if (rd_a !== 1'b1 || addr_a !== 32'h00002003) begin
      errors++; $display("FAIL dump_byte3: rd=%b addr=%h required 1 00002003", rd_a, addr_a);
    end
    tick(2);
    checks++;
    if (dv_a !== 1'b1 || daddr_a !== 32'h00002000 || ddata_a !== 32'h01020304) begin
      errors++; $display("FAIL word0: valid=%b addr=%h data=%h required 1 00002000 01020304", dv_a, daddr_a, ddata_a);
    end
    tick(1);
    checks++;
    if (dv_a !== 1'b0 || ws_a !== 16'd1 || addr_a !== 32'h00002004) begin
      errors++; $display("FAIL after_word0: valid=%b ws=%0d addr=%h required 0 1 00002004", dv_a, ws_a, addr_a);
    end
    tick(5);
    checks++;
    if (dv_a !== 1'b1 || daddr_a !== 32'h00002004 || ddata_a !== 32'hAABBCCDD) begin
      errors++; $display("FAIL word1: valid=%b addr=%h data=%h required 1 00002004 AABBCCDD", dv_a, daddr_a, ddata_a);
    end
    tick(1);
    checks++;
    if (done_a !== 1'b1 || halt_a !== 1'b1 || ws_a !== 16'd2 || dv_a !== 1'b0) begin
      errors++; $display("FAIL dump_done: done=%b halt=%b ws=%0d valid=%b required 1 1 2 0", done_a, halt_a, ws_a, dv_a);
    end
    // Trap still presented while done: must be ignored.
    tick(8);
    checks++;
    if (done_a !== 1'b1 || ws_a !== 16'd2 || rd_a !== 1'b0 || dv_a !== 1'b0) begin
      errors++; $display("FAIL done_hold: done=%b ws=%0d rd=%b valid=%b required 1 2 0 0", done_a, ws_a, rd_a, dv_a);
    end
  endtask

  task automatic test_stall();
    en_a = 1'b0; ins_a = 32'h0; rdy_a = 1'b0;
    do_reset();
    en_a = 1'b1; ins_a = TRAP;
    tick(6);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (dv_a !== 1'b1 || daddr_a !== 32'h00002000 || ddata_a !== 32'h01020304 || rd_a !== 1'b0 || ws_a !== 16'd0) begin
        errors++; $display("FAIL stall cycle %0d: valid=%b addr=%h data=%h rd=%b ws=%0d required 1 00002000 01020304 0 0",
          i, dv_a, daddr_a, ddata_a, rd_a, ws_a);
      end
      tick(1);
    end
    rdy_a = 1'b1;
    tick(1);
    rdy_a = 1'b0;
    checks++;
    if (ws_a !== 16'd1 || dv_a !== 1'b0 || rd_a !== 1'b1 || addr_a !== 32'h00002004) begin
      errors++; $display("FAIL stall_release: ws=%0d valid=%b rd=%b addr=%h required 1 0 1 00002004", ws_a, dv_a, rd_a, addr_a);
    end
    tick(3);
    checks++;
    if (ws_a !== 16'd1) begin
      errors++; $display("FAIL single_transfer: ws=%0d required 1", ws_a);
    end
  endtask

  task automatic test_zero();
    en_z = 1'b1; ins_z = TRAP;
    tick(1);
    checks++;
    if (halt_z !== 1'b1 || done_z !== 1'b1 || dv_z !== 1'b0 || rd_z !== 1'b0) begin
      errors++; $display("FAIL zero_words: halt=%b done=%b valid=%b rd=%b required 1 1 0 0", halt_z, done_z, dv_z, rd_z);
    end
    tick(10);
    checks++;
    if (zero_valid_seen !== 0 || ws_z !== 16'd0) begin
      errors++; $display("FAIL zero_no_valid: valid cycles=%0d ws=%0d required 0 0", zero_valid_seen, ws_z);
    end
  endtask

  task automatic test_wrap();
    rdy_w = 1'b1; en_w = 1'b1; ins_w = TRAP;
    tick(1);
    checks++;
    if (rd_w !== 1'b1 || addr_w !== 32'hFFFFFFFC) begin
      errors++; $display("FAIL wrap_start: rd=%b addr=%h required 1 FFFFFFFC", rd_w, addr_w);
    end
    tick(5);
    checks++;
    if (dv_w !== 1'b1 || daddr_w !== 32'hFFFFFFFC || ddata_w !== 32'h11223344) begin
      errors++; $display("FAIL wrap_word0: valid=%b addr=%h data=%h required 1 FFFFFFFC 11223344", dv_w, daddr_w, ddata_w);
    end
    tick(1);
    checks++;
    if (rd_w !== 1'b1 || addr_w !== 32'h00000000) begin
      errors++; $display("FAIL wrap_read0: rd=%b addr=%h required 1 00000000", rd_w, addr_w);
    end
    tick(3);
    checks++;
    if (rd_w !== 1'b1 || addr_w !== 32'h00000003) begin
      errors++; $display("FAIL wrap_read3: rd=%b addr=%h required 1 00000003", rd_w, addr_w);
    end
    tick(2);
    checks++;
    if (dv_w !== 1'b1 || daddr_w !== 32'h00000000 || ddata_w !== 32'h55667788) begin
      errors++; $display("FAIL wrap_word1: valid=%b addr=%h data=%h required 1 00000000 55667788", dv_w, daddr_w, ddata_w);
    end
    tick(1);
    checks++;
    if (done_w !== 1'b1 || ws_w !== 16'd2) begin
      errors++; $display("FAIL wrap_done: done=%b ws=%0d required 1 2", done_w, ws_w);
    end
  endtask

  task automatic test_reset_mid();
    en_a = 1'b0; ins_a = 32'h0; rdy_a = 1'b1;
    do_reset();
    en_a = 1'b1; ins_a = TRAP;
    tick(8);
    checks++;
    if (rd_a !== 1'b1 || addr_a !== 32'h00002005 || ws_a !== 16'd1) begin
      errors++; $display("FAIL mid_position: rd=%b addr=%h ws=%0d required 1 00002005 1", rd_a, addr_a, ws_a);
    end
    reset = 1'b1; en_a = 1'b0;
    tick(1);
    checks++;
    if ({halt_a, rd_a, dv_a, done_a} !== 4'b0000 || {addr_a, daddr_a, ddata_a, ws_a} !== 112'h0) begin
      errors++; $display("FAIL mid_reset: halt/rd/valid/done=%b addr=%h daddr=%h ddata=%h ws=%0d required all zero",
        {halt_a, rd_a, dv_a, done_a}, addr_a, daddr_a, ddata_a, ws_a);
    end
    reset = 1'b0;
    tick(1);
    en_a = 1'b1;
    tick(1);
    checks++;
    if (halt_a !== 1'b1 || rd_a !== 1'b1 || addr_a !== 32'h00002000 || ws_a !== 16'd0) begin
      errors++; $display("FAIL restart: halt=%b rd=%b addr=%h ws=%0d required 1 1 00002000 0", halt_a, rd_a, addr_a, ws_a);
    end
    tick(5);
    checks++;
    if (dv_a !== 1'b1 || daddr_a !== 32'h00002000 || ddata_a !== 32'h01020304) begin
      errors++; $display("FAIL restart_word0: valid=%b addr=%h data=%h required 1 00002000 01020304", dv_a, daddr_a, ddata_a);
    end
    tick(1);
    checks++;
    if (ws_a !== 16'd1) begin
      errors++; $display("FAIL restart_count: ws=%0d required 1", ws_a);
    end
  endtask

  initial begin
    test_reset();
    test_no_trap();
    test_enable_low();
    test_dump_two();
    test_stall();
    test_zero();
    test_wrap();
    test_reset_mid();
    checks++;
    if (addr_viol !== 0) begin
      errors++; $display("FAIL addr_idle_zero: violations=%0d required 0", addr_viol);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
